// File: rtl/align_s2p_flex.sv
// -----------------------------------------------------------------------------
// align_s2p_flex
//
// Serial-to-parallel packer. Accepts one IDATA_BIT-wide element per cycle and
// packs them, lane 0 first, into a GBUS_DATA-wide word. A word is closed when
// it reaches the configured element count, when an element arrives with
// idata_last, or when flush is asserted. Closed words pass through a one-deep
// output register with a valid/ready handshake.
//
// Storage is two stages:
//   packing register : pack_data / fill_cnt / pack_last (word being built)
//   output register  : odata / odata_mask / odata_last / odata_valid
// If the output register is still occupied when a word closes, the closed
// word waits in the packing register (PEND) and input is stalled.
//
// Ports
//   clk           sole clock, rising edge
//   rst           synchronous active-high reset
//   cfg_pack_num  elements per word; 0 or > REG_NUM selects REG_NUM
//   idata         input element
//   idata_valid   element present
//   idata_last    closes the current word after this element
//   idata_ready   block accepts an element this cycle (registered state only)
//   flush         close the current partial word without new data
//   odata         packed word, lane k at [k*IDATA_BIT +: IDATA_BIT]
//   odata_mask    bit k set when lane k holds valid data
//   odata_last    word was closed by idata_last or flush
//   odata_valid   output word present
//   odata_ready   consumer takes the word on odata_valid && odata_ready
//   fill_cnt      elements held in the packing register
// -----------------------------------------------------------------------------
module align_s2p_flex #(
  parameter int IDATA_BIT = 8,
  parameter int GBUS_DATA = 64,
  parameter int CNT_BIT   = $clog2(GBUS_DATA / IDATA_BIT + 1)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [CNT_BIT-1:0]                cfg_pack_num,
  input  logic [IDATA_BIT-1:0]              idata,
  input  logic                              idata_valid,
  input  logic                              idata_last,
  output logic                              idata_ready,
  input  logic                              flush,
  output logic [GBUS_DATA-1:0]              odata,
  output logic [GBUS_DATA/IDATA_BIT-1:0]    odata_mask,
  output logic                              odata_last,
  output logic                              odata_valid,
  input  logic                              odata_ready,
  output logic [CNT_BIT-1:0]                fill_cnt
);

  localparam int                 REG_NUM   = GBUS_DATA / IDATA_BIT;
  localparam logic [CNT_BIT-1:0] REG_NUM_C = CNT_BIT'(REG_NUM);

  typedef enum logic [0:0] {
    FILL = 1'b0,   // building a word, input open
    PEND = 1'b1    // closed word waiting for the output slot, input stalled
  } state_t;

  state_t state, state_nxt;

  // Packing register
  logic [GBUS_DATA-1:0] pack_data, pack_data_nxt;
  logic                 pack_last, pack_last_nxt;
  logic [CNT_BIT-1:0]   fill_cnt_nxt;

  // Candidate word presented to the output register
  logic                 load_out;
  logic [GBUS_DATA-1:0] word_data;
  logic [CNT_BIT-1:0]   word_cnt;
  logic                 word_last;
  logic [REG_NUM-1:0]   word_mask;

  logic                 accept;
  logic                 slot_free;
  logic                 close_word;
  logic [CNT_BIT-1:0]   eff_num;
  logic [CNT_BIT-1:0]   fill_inc;

  // Out-of-range configuration (0 or more lanes than exist) means a full word.
  assign eff_num = ((cfg_pack_num == '0) || (cfg_pack_num > REG_NUM_C))
                   ? REG_NUM_C : cfg_pack_num;

  // Ready depends only on registered state and reset, never on odata_ready,
  // so no combinational path runs from the consumer back to the producer.
  assign idata_ready = (state == FILL) && !rst;
  assign accept      = idata_valid && idata_ready;
  assign slot_free   = !odata_valid || odata_ready;

  // fill_cnt never exceeds REG_NUM-1 while in FILL (the accept that would
  // reach eff_num closes the word), so the increment cannot overflow CNT_BIT.
  assign fill_inc    = fill_cnt + CNT_BIT'(1);

  // ---------------------------------------------------------------------------
  // Next-state and datapath decode
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    state_nxt     = state;
    fill_cnt_nxt  = fill_cnt;
    pack_data_nxt = pack_data;
    pack_last_nxt = pack_last;
    load_out      = 1'b0;
    close_word    = 1'b0;
    word_data     = pack_data;
    word_cnt      = fill_cnt;
    word_last     = pack_last;

    case (state)
      FILL: begin
        if (accept) begin
          for (int k = 0; k < REG_NUM; k++) begin
            if (fill_cnt == CNT_BIT'(k)) begin
              word_data[k*IDATA_BIT +: IDATA_BIT] = idata;
            end
          end
          word_cnt   = fill_inc;
          word_last  = idata_last || flush;
          // ">=" rather than "==" so that lowering cfg_pack_num below the
          // current fill closes the word on the very next accept.
          close_word = (fill_inc >= eff_num) || idata_last || flush;
        end else if (flush && (fill_cnt != '0)) begin
          word_last  = 1'b1;
          close_word = 1'b1;
        end
        // flush with an empty packing register and no accept: nothing to close.

        if (close_word) begin
          if (slot_free) begin
            load_out      = 1'b1;
            fill_cnt_nxt  = '0;
            pack_data_nxt = '0;
            pack_last_nxt = 1'b0;
          end else begin
            // Park the finished word; fill_cnt keeps its final count.
            state_nxt     = PEND;
            fill_cnt_nxt  = word_cnt;
            pack_data_nxt = word_data;
            pack_last_nxt = word_last;
          end
        end else if (accept) begin
          fill_cnt_nxt  = word_cnt;
          pack_data_nxt = word_data;
        end
      end

      PEND: begin
        // flush is ignored here; the parked word is already closed.
        if (slot_free) begin
          load_out      = 1'b1;
          state_nxt     = FILL;
          fill_cnt_nxt  = '0;
          pack_data_nxt = '0;
          pack_last_nxt = 1'b0;
        end
      end

      default: begin
        state_nxt = FILL;
      end
    endcase
  end

  // Lane mask is contiguous from bit 0, one bit per element in the word.
  always_comb begin
    word_mask = '0;
    for (int k = 0; k < REG_NUM; k++) begin
      word_mask[k] = (CNT_BIT'(k) < word_cnt);
    end
  end

  // ---------------------------------------------------------------------------
  // Packing register and FSM state
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FILL;
      fill_cnt  <= '0;
      // NOTE: the packing data register is reset (not just its count) because
      // unfilled lanes are forwarded as-is and must read as zero.
      pack_data <= '0;
      pack_last <= 1'b0;
    end else begin
      state     <= state_nxt;
      fill_cnt  <= fill_cnt_nxt;
      pack_data <= pack_data_nxt;
      pack_last <= pack_last_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Output register
  // ---------------------------------------------------------------------------
  // Contents only change on a load, and a load only happens when the slot is
  // free, so the word is stable while odata_valid && !odata_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      odata       <= '0;
      odata_mask  <= '0;
      odata_last  <= 1'b0;
      odata_valid <= 1'b0;
    end else if (load_out) begin
      odata       <= word_data;
      odata_mask  <= word_mask;
      odata_last  <= word_last;
      odata_valid <= 1'b1;
    end else if (odata_ready) begin
      odata_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_align_s2p_flex.sv
// -----------------------------------------------------------------------------
// tb_align_s2p_flex
//
// Directed testbench for align_s2p_flex (IDATA_BIT=8, GBUS_DATA=64). Inputs
// are driven 1 time unit after each rising edge and outputs are sampled at
// the same point, after the registers have settled.
// -----------------------------------------------------------------------------
module tb_align_s2p_flex;

  localparam int IDATA_BIT = 8;
  localparam int GBUS_DATA = 64;
  localparam int REG_NUM   = GBUS_DATA / IDATA_BIT;
  localparam int CNT_BIT   = $clog2(REG_NUM + 1);

  logic                 clk;
  logic                 rst;
  logic [CNT_BIT-1:0]   cfg_pack_num;
  logic [IDATA_BIT-1:0] idata;
  logic                 idata_valid;
  logic                 idata_last;
  logic                 idata_ready;
  logic                 flush;
  logic [GBUS_DATA-1:0] odata;
  logic [REG_NUM-1:0]   odata_mask;
  logic                 odata_last;
  logic                 odata_valid;
  logic                 odata_ready;
  logic [CNT_BIT-1:0]   fill_cnt;

  int tests_run    = 0;
  int tests_failed = 0;

  align_s2p_flex #(
    .IDATA_BIT (IDATA_BIT),
    .GBUS_DATA (GBUS_DATA),
    .CNT_BIT   (CNT_BIT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_pack_num (cfg_pack_num),
    .idata        (idata),
    .idata_valid  (idata_valid),
    .idata_last   (idata_last),
    .idata_ready  (idata_ready),
    .flush        (flush),
    .odata        (odata),
    .odata_mask   (odata_mask),
    .odata_last   (odata_last),
    .odata_valid  (odata_valid),
    .odata_ready  (odata_ready),
    .fill_cnt     (fill_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drop all inputs, keep the consumer ready and let any word drain.
  task automatic idle(input int n);
    idata_valid = 1'b0;
    idata_last  = 1'b0;
    flush       = 1'b0;
    odata_ready = 1'b1;
    for (int i = 0; i < n; i++) step();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst          = 1'b1;
    cfg_pack_num = CNT_BIT'(8);
    idata        = '0;
    idata_valid  = 1'b0;
    idata_last   = 1'b0;
    flush        = 1'b0;
    odata_ready  = 1'b1;
    step();
    step();
    tests_run++; if (idata_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_ready_low: got %b expected 0", idata_ready); end
    tests_run++; if (odata_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b expected 0", odata_valid); end
    tests_run++; if (fill_cnt !== '0) begin tests_failed++; $display("FAIL reset_fill_cnt: got %0d expected 0", fill_cnt); end
    tests_run++; if (odata !== '0) begin tests_failed++; $display("FAIL reset_odata: got %h expected 0", odata); end
    tests_run++; if (odata_mask !== '0 || odata_last !== 1'b0) begin tests_failed++; $display("FAIL reset_mask_last: got %h/%b expected 00/0", odata_mask, odata_last); end
    rst = 1'b0;
    #1;
    tests_run++; if (idata_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready_after: got %b expected 1", idata_ready); end
    step();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_full_word();
    cfg_pack_num = CNT_BIT'(8);
    odata_ready  = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      idata       = IDATA_BIT'(i);
      idata_valid = 1'b1;
      step();
      if (i == 4) begin
        tests_run++; if (fill_cnt !== CNT_BIT'(4)) begin tests_failed++; $display("FAIL full_fill_cnt4: got %0d expected 4", fill_cnt); end
      end
      if (i == 7) begin
        tests_run++; if (odata_valid !== 1'b0) begin tests_failed++; $display("FAIL full_early_valid: got %b expected 0", odata_valid); end
      end
    end
    idata_valid = 1'b0;
    tests_run++; if (odata_valid !== 1'b1) begin tests_failed++; $display("FAIL full_valid: got %b expected 1", odata_valid); end
    tests_run++; if (odata !== 64'h0807060504030201) begin tests_failed++; $display("FAIL full_odata: got %h expected 0807060504030201", odata); end
    tests_run++; if (odata_mask !== 8'hFF) begin tests_failed++; $display("FAIL full_mask: got %h expected ff", odata_mask); end
    tests_run++; if (odata_last !== 1'b0) begin tests_failed++; $display("FAIL full_last: got %b expected 0", odata_last); end
    tests_run++; if (fill_cnt !== '0) begin tests_failed++; $display("FAIL full_fill_cnt0: got %0d expected 0", fill_cnt); end
    step();
    tests_run++; if (odata_valid !== 1'b0) begin tests_failed++; $display("FAIL full_valid_one_cycle: got %b expected 0", odata_valid); end
    idle(2);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_pack3();
    cfg_pack_num = CNT_BIT'(3);
    odata_ready  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      idata       = IDATA_BIT'(8'h0A + i);
      idata_valid = 1'b1;
      step();
      if (i == 2) begin
        tests_run++; if (odata_valid !== 1'b1 || odata !== 64'h0C0B0A || odata_mask !== 8'h07) begin tests_failed++; $display("FAIL pack3_word0: got v=%b %h/%h expected v=1 0c0b0a/07", odata_valid, odata, odata_mask); end
      end
      if (i == 3) begin
        tests_run++; if (odata_valid !== 1'b0) begin tests_failed++; $display("FAIL pack3_gap: got %b expected 0", odata_valid); end
      end
      if (i == 5) begin
        tests_run++; if (odata_valid !== 1'b1 || odata !== 64'h0F0E0D || odata_mask !== 8'h07) begin tests_failed++; $display("FAIL pack3_word1: got v=%b %h/%h expected v=1 0f0e0d/07", odata_valid, odata, odata_mask); end
      end
    end
    idle(2);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_flush();
    cfg_pack_num = CNT_BIT'(8);
    odata_ready  = 1'b1;
    idata_valid  = 1'b1;
    idata        = 8'h11; step();
    idata        = 8'h22; step();
    idata_valid  = 1'b0;
    tests_run++; if (fill_cnt !== CNT_BIT'(2)) begin tests_failed++; $display("FAIL flush_fill_cnt: got %0d expected 2", fill_cnt); end
    flush = 1'b1;
    step();
    tests_run++; if (odata_valid !== 1'b1 || odata !== 64'h2211) begin tests_failed++; $display("FAIL flush_word: got v=%b %h expected v=1 2211", odata_valid, odata); end
    tests_run++; if (odata_mask !== 8'h03 || odata_last !== 1'b1) begin tests_failed++; $display("FAIL flush_mask_last: got %h/%b expected 03/1", odata_mask, odata_last); end
    // flush kept high with nothing buffered must not create a word
    step();
    tests_run++; if (odata_valid !== 1'b0 || fill_cnt !== '0) begin tests_failed++; $display("FAIL flush_empty: got v=%b cnt=%0d expected v=0 cnt=0", odata_valid, fill_cnt); end
    step();
    tests_run++; if (odata_valid !== 1'b0) begin tests_failed++; $display("FAIL flush_empty2: got %b expected 0", odata_valid); end
    idle(2);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_backpressure();
    cfg_pack_num = CNT_BIT'(8);
    odata_ready  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      idata       = IDATA_BIT'(8'h31 + i);
      idata_valid = 1'b1;
      step();
    end
    idata_valid = 1'b0;
    tests_run++; if (idata_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_ready_low: got %b expected 0", idata_ready); end
    tests_run++; if (fill_cnt !== CNT_BIT'(8)) begin tests_failed++; $display("FAIL bp_fill_cnt: got %0d expected 8", fill_cnt); end
    tests_run++; if (odata_valid !== 1'b1 || odata !== 64'h3837363534333231) begin tests_failed++; $display("FAIL bp_word0: got v=%b %h expected v=1 3837363534333231", odata_valid, odata); end
    step();
    tests_run++; if (odata !== 64'h3837363534333231 || odata_mask !== 8'hFF || odata_valid !== 1'b1) begin tests_failed++; $display("FAIL bp_stable: got v=%b %h/%h expected v=1 3837363534333231/ff", odata_valid, odata, odata_mask); end
    odata_ready = 1'b1;
    step();
    tests_run++; if (odata_valid !== 1'b1 || odata !== 64'h403F3E3D3C3B3A39) begin tests_failed++; $display("FAIL bp_word1: got v=%b %h expected v=1 403f3e3d3c3b3a39", odata_valid, odata); end
    tests_run++; if (idata_ready !== 1'b1 || fill_cnt !== '0) begin tests_failed++; $display("FAIL bp_resume: got rdy=%b cnt=%0d expected rdy=1 cnt=0", idata_ready, fill_cnt); end
    step();
    tests_run++; if (odata_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_drain: got %b expected 0", odata_valid); end
    idle(2);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_last();
    // 15 is above REG_NUM, so the effective size is a full word; idata_last closes early.
    cfg_pack_num = CNT_BIT'(15);
    odata_ready  = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      idata       = IDATA_BIT'(i);
      idata_valid = 1'b1;
      idata_last  = (i == 5);
      step();
    end
    idata_valid = 1'b0;
    idata_last  = 1'b0;
    tests_run++; if (odata_valid !== 1'b1 || odata !== 64'h0000000504030201) begin tests_failed++; $display("FAIL last_word: got v=%b %h expected v=1 0000000504030201", odata_valid, odata); end
    tests_run++; if (odata_mask !== 8'h1F || odata_last !== 1'b1) begin tests_failed++; $display("FAIL last_mask_last: got %h/%b expected 1f/1", odata_mask, odata_last); end
    idle(2);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_cfg_change();
    cfg_pack_num = CNT_BIT'(8);
    odata_ready  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      idata       = IDATA_BIT'(8'h51 + i);
      idata_valid = 1'b1;
      step();
    end
    tests_run++; if (fill_cnt !== CNT_BIT'(5) || odata_valid !== 1'b0) begin tests_failed++; $display("FAIL cfg_partial: got cnt=%0d v=%b expected cnt=5 v=0", fill_cnt, odata_valid); end
    cfg_pack_num = CNT_BIT'(3);
    idata        = 8'h56;
    step();
    idata_valid  = 1'b0;
    tests_run++; if (odata_valid !== 1'b1 || odata !== 64'h0000565554535251) begin tests_failed++; $display("FAIL cfg_shrink_word: got v=%b %h expected v=1 0000565554535251", odata_valid, odata); end
    tests_run++; if (odata_mask !== 8'h3F || odata_last !== 1'b0) begin tests_failed++; $display("FAIL cfg_shrink_mask: got %h/%b expected 3f/0", odata_mask, odata_last); end
    idle(2);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_back_to_back();
    cfg_pack_num = CNT_BIT'(1);
    odata_ready  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idata       = IDATA_BIT'(8'h71 + i);
      idata_valid = 1'b1;
      step();
      tests_run++; if (odata_valid !== 1'b1 || odata !== GBUS_DATA'(8'h71 + i) || odata_mask !== 8'h01) begin tests_failed++; $display("FAIL b2b_word%0d: got v=%b %h/%h expected v=1 %h/01", i, odata_valid, odata, odata_mask, 8'h71 + i); end
    end
    idle(2);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_midop();
    cfg_pack_num = CNT_BIT'(8);
    odata_ready  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      idata       = IDATA_BIT'(8'h61 + i);
      idata_valid = 1'b1;
      step();
    end
    tests_run++; if (fill_cnt !== CNT_BIT'(4)) begin tests_failed++; $display("FAIL rstmid_fill_cnt4: got %0d expected 4", fill_cnt); end
    // Element offered during reset must not be taken.
    rst   = 1'b1;
    idata = 8'hEE;
    #1;
    tests_run++; if (idata_ready !== 1'b0) begin tests_failed++; $display("FAIL rstmid_ready: got %b expected 0", idata_ready); end
    step();
    rst         = 1'b0;
    idata_valid = 1'b0;
    tests_run++; if (fill_cnt !== '0 || odata_valid !== 1'b0) begin tests_failed++; $display("FAIL rstmid_cleared: got cnt=%0d v=%b expected cnt=0 v=0", fill_cnt, odata_valid); end
    // cfg 0 selects a full word
    cfg_pack_num = '0;
    for (int i = 0; i < 8; i++) begin
      idata       = IDATA_BIT'(8'h21 + i);
      idata_valid = 1'b1;
      step();
    end
    idata_valid = 1'b0;
    tests_run++; if (odata_valid !== 1'b1 || odata !== 64'h2827262524232221) begin tests_failed++; $display("FAIL rstmid_word: got v=%b %h expected v=1 2827262524232221", odata_valid, odata); end
    tests_run++; if (odata_mask !== 8'hFF || odata_last !== 1'b0) begin tests_failed++; $display("FAIL rstmid_mask: got %h/%b expected ff/0", odata_mask, odata_last); end
    idle(2);
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_full_word();
    test_pack3();
    test_flush();
    test_backpressure();
    test_last();
    test_cfg_change();
    test_back_to_back();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/align_s2p_flex.md
ALIGN_S2P_FLEX -- requirements
Module: align_s2p_flex

Interface
REQ-001 SHALL have parameter IDATA_BIT, default 8: element width in bits.
REQ-002 SHALL have parameter GBUS_DATA, default 64: packed word width; GBUS_DATA SHALL be an integer multiple of IDATA_BIT; REG_NUM = GBUS_DATA/IDATA_BIT lanes.
REQ-003 SHALL have parameter CNT_BIT, default $clog2(REG_NUM+1): width of counts.
REQ-004 clk  in  1  sole clock; all state changes on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 cfg_pack_num  in  CNT_BIT  elements per word; 0 or >REG_NUM means REG_NUM.
REQ-007 idata  in  IDATA_BIT  input element.
REQ-008 idata_valid  in  1  element present.
REQ-009 idata_last  in  1  qualifies idata; closes current word after this element.
REQ-010 idata_ready  out  1  block accepts an element this cycle.
REQ-011 flush  in  1  close current partial word without new data.
REQ-012 odata  out  GBUS_DATA  packed word; lane k at bits [k*IDATA_BIT +: IDATA_BIT].
REQ-013 odata_mask  out  REG_NUM  bit k = 1 when lane k holds valid data.
REQ-014 odata_last  out  1  word was closed by idata_last or flush.
REQ-015 odata_valid  out  1  output word present.
REQ-016 odata_ready  in  1  consumer takes word when odata_valid && odata_ready.
REQ-017 fill_cnt  out  CNT_BIT  elements held in the packing register.

Function
REQ-018 Element accepted when idata_valid && idata_ready; written to lane fill_cnt; fill_cnt increments.
REQ-019 Two-stage storage: packing register (fill, mask, last) and output register (odata, odata_mask, odata_last, odata_valid).
REQ-020 FSM states FILL and PEND; idata_ready = (state==FILL) && !rst, registered state only, no path from odata_ready.
REQ-021 Word closes in FILL when an accept makes fill_cnt+1 >= effective cfg_pack_num, or accepted element has idata_last, or flush with an accept, or flush with fill_cnt>0 and no accept.
REQ-022 flush in FILL with fill_cnt==0 and no accept SHALL be ignored (no empty word); flush in PEND SHALL be ignored.
REQ-023 Output slot free = !odata_valid || odata_ready.
REQ-024 On close with slot free: word moves to output register at that edge, fill_cnt -> 0, state stays FILL; latency one cycle from closing accept to odata_valid.
REQ-025 On close with slot not free: state -> PEND, fill_cnt holds final count; in PEND when slot free, word moves to output register, fill_cnt -> 0, state -> FILL.
REQ-026 Unfilled lanes of odata SHALL be zero; odata_mask SHALL be contiguous from bit 0 with popcount = elements in word.
REQ-027 odata, odata_mask, odata_last SHALL be stable while odata_valid && !odata_ready.
REQ-028 odata_valid clears after a handshake unless a new word loads on the same edge; back-to-back words at full rate when odata_ready is held high.
REQ-029 cfg_pack_num changes take effect on the next accept; if fill_cnt already >= new value, the next accept closes the word.
REQ-030 Word order SHALL be preserved; no element dropped or duplicated except by reset.

Reset
REQ-031 While rst high at a clock edge: state -> FILL, fill_cnt=0, odata=0, odata_mask=0, odata_last=0, odata_valid=0; idata_ready=0 while rst high, 1 in first cycle after deassertion.
REQ-032 Reset mid-operation SHALL discard partial and pending words; no handshake is honoured on the reset edge.

Verification (IDATA_BIT=8, GBUS_DATA=64, REG_NUM=8)
REQ-033 cfg_pack_num=8, odata_ready=1, feed 0x01..0x08 back-to-back -> one cycle after 8th accept odata=0x0807060504030201, mask=0xFF, last=0, valid one cycle.
REQ-034 cfg_pack_num=3, feed 0x0A..0x0F -> odata 0x0C0B0A mask 0x07, then 0x0F0E0D mask 0x07.
REQ-035 Feed 0x11,0x22 then flush alone -> odata=0x2211, mask=0x03, last=1; subsequent flush with fill_cnt=0 -> no word.
REQ-036 odata_ready=0, cfg_pack_num=8, feed 16 elements -> idata_ready=0 after 16th accept, fill_cnt=8; raise odata_ready -> two words in order, idata_ready=1 one cycle after first handshake.
REQ-037 Five elements 0x01..0x05 with idata_last (or flush) on 5th -> odata=0x0504030201, mask=0x1F, last=1.
REQ-038 After 4 accepts assert rst one cycle -> fill_cnt=0, odata_valid=0; next 8 elements 0x21..0x28 yield 0x2827262524232221, mask 0xFF.
